// File: rtl/midi_voice_allocator.sv
// MIDI byte parser with running status feeding an LRU polyphonic voice allocator.
// Optional macro VOICE_STEAL_EN: a note-on with every voice gated steals the oldest voice.

module midi_voice_slot #(
   parameter int RW  = 2,
   parameter int IDX = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          bump,
   input  logic          clr_gate,
   input  logic [6:0]    new_note,
   input  logic [6:0]    new_vel,
   output logic [6:0]    note,
   output logic [6:0]    vel,
   output logic          gate,
   output logic          trig,
   output logic [RW-1:0] rank
);
   logic [6:0]    note_q, note_d, vel_q, vel_d;
   logic          gate_q, gate_d, trig_q, trig_d;
   logic [RW-1:0] rank_q, rank_d;

   always_comb begin
      note_d = note_q;
      vel_d  = vel_q;
      gate_d = gate_q;
      trig_d = 1'b0;
      rank_d = rank_q;
      if (start) begin
         note_d = new_note;
         vel_d  = new_vel;
         gate_d = 1'b1;
         trig_d = 1'b1;
         rank_d = '0;
      end else begin
         if (bump)     rank_d = rank_q + RW'(1);
         if (clr_gate) gate_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note_q <= '0;
         vel_q  <= '0;
         gate_q <= 1'b0;
         trig_q <= 1'b0;
         rank_q <= RW'(IDX);
      end else begin
         note_q <= note_d;
         vel_q  <= vel_d;
         gate_q <= gate_d;
         trig_q <= trig_d;
         rank_q <= rank_d;
      end
   end

   assign note = note_q;
   assign vel  = vel_q;
   assign gate = gate_q;
   assign trig = trig_q;
   assign rank = rank_q;
endmodule

module midi_voice_allocator #(
   parameter int VOICES = 4,
   parameter int OMNI   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            rx_byte,
   input  logic                  rx_valid,
   input  logic [3:0]            channel,
   output logic [7*VOICES-1:0]   voice_note,
   output logic [7*VOICES-1:0]   voice_vel,
   output logic [VOICES-1:0]     voice_gate,
   output logic [VOICES-1:0]     voice_trig,
   output logic                  overflow
);
   localparam int RW = $clog2(VOICES);

   typedef enum logic [1:0] {NOSTAT, WAIT_D1, WAIT_D2} pstate_t;
   typedef enum logic [1:0] {EV_NONE, EV_ON, EV_OFF, EV_ALLOFF} ev_t;

   pstate_t    state_q, state_d;
   logic [7:0] status_q, status_d;
   logic [6:0] d1_q, d1_d;
   ev_t        ev_q, ev_d;
   logic [6:0] ev_note_q, ev_note_d, ev_vel_q, ev_vel_d;
   logic       overflow_q, overflow_d;
   logic       complete, ch_ok;

   logic [VOICES-1:0][6:0]    note_w, vel_w;
   logic [VOICES-1:0][RW-1:0] rank_w;
   logic [VOICES-1:0]         gate_w, trig_w, hit, clr, start_vec, bump;
   logic [RW-1:0]             hit_idx, free_idx, tgt, tgt_rank;
   logic                      start_any;

   assign ch_ok = (OMNI != 0) || (status_q[3:0] == channel);

   // Parser: real-time bytes fall through untouched so they can interleave anywhere.
   always_comb begin
      state_d   = state_q;
      status_d  = status_q;
      d1_d      = d1_q;
      complete  = 1'b0;
      ev_d      = EV_NONE;
      ev_note_d = ev_note_q;
      ev_vel_d  = ev_vel_q;
      if (rx_valid) begin
         if (rx_byte[7:3] == 5'b11111) begin
            state_d = state_q;
         end else if (rx_byte[7:4] == 4'hF) begin
            status_d = '0;
            state_d  = NOSTAT;
         end else if (rx_byte[7]) begin
            status_d = rx_byte;
            state_d  = WAIT_D1;
         end else begin
            case (state_q)
               WAIT_D1: begin
                  d1_d = rx_byte[6:0];
                  if (status_q[7:4] == 4'hC || status_q[7:4] == 4'hD) state_d = WAIT_D1;
                  else                                                state_d = WAIT_D2;
               end
               WAIT_D2: begin
                  complete = 1'b1;
                  state_d  = WAIT_D1;
               end
               default: state_d = NOSTAT;
            endcase
         end
      end
      if (complete && ch_ok) begin
         ev_note_d = d1_q;
         ev_vel_d  = rx_byte[6:0];
         case (status_q[7:4])
            4'h9:    ev_d = (rx_byte[6:0] != 7'd0) ? EV_ON : EV_OFF;
            4'h8:    ev_d = EV_OFF;
            4'hB:    ev_d = (d1_q == 7'd123) ? EV_ALLOFF : EV_NONE;
            default: ev_d = EV_NONE;
         endcase
      end
   end

   // Lowest-index search: iterate downward so the smallest match wins.
   always_comb begin
      hit      = '0;
      hit_idx  = '0;
      free_idx = '0;
      for (int i = VOICES-1; i >= 0; i--) begin
         hit[i] = gate_w[i] && (note_w[i] == ev_note_q);
         if (gate_w[i] && (note_w[i] == ev_note_q)) hit_idx = RW'(i);
         if (!gate_w[i]) free_idx = RW'(i);
      end
   end

`ifdef VOICE_STEAL_EN
   logic [RW-1:0] old_idx;
   always_comb begin
      old_idx = '0;
      for (int i = 0; i < VOICES; i++)
         if (rank_w[i] == RW'(VOICES-1)) old_idx = RW'(i);
   end
`endif

   always_comb begin
      start_any  = 1'b0;
      tgt        = '0;
      clr        = '0;
      overflow_d = 1'b0;
      case (ev_q)
         EV_ON: begin
            if (|hit) begin
               start_any = 1'b1;
               tgt       = hit_idx;
            end else if (!(&gate_w)) begin
               start_any = 1'b1;
               tgt       = free_idx;
            end else begin
               overflow_d = 1'b1;
`ifdef VOICE_STEAL_EN
               start_any  = 1'b1;
               tgt        = old_idx;
`endif
            end
         end
         EV_OFF:    clr = hit;
         EV_ALLOFF: clr = '1;
         default:   clr = '0;
      endcase
   end

   assign tgt_rank = rank_w[tgt];

   for (genvar i = 0; i < VOICES; i++) begin : g_voice
      assign start_vec[i] = start_any && (tgt == RW'(i));
      assign bump[i]      = start_any && (rank_w[i] < tgt_rank);
      midi_voice_slot #(.RW(RW), .IDX(i)) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .start    (start_vec[i]),
         .bump     (bump[i]),
         .clr_gate (clr[i]),
         .new_note (ev_note_q),
         .new_vel  (ev_vel_q),
         .note     (note_w[i]),
         .vel      (vel_w[i]),
         .gate     (gate_w[i]),
         .trig     (trig_w[i]),
         .rank     (rank_w[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= NOSTAT;
         status_q   <= '0;
         d1_q       <= '0;
         ev_q       <= EV_NONE;
         ev_note_q  <= '0;
         ev_vel_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         status_q   <= status_d;
         d1_q       <= d1_d;
         ev_q       <= ev_d;
         ev_note_q  <= ev_note_d;
         ev_vel_q   <= ev_vel_d;
         overflow_q <= overflow_d;
      end
   end

   assign voice_note = note_w;
   assign voice_vel  = vel_w;
   assign voice_gate = gate_w;
   assign voice_trig = trig_w;
   assign overflow   = overflow_q;
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench: two DUTs (OMNI=0 and OMNI=1) on one byte stream, checked every cycle
// against a behavioural parser/allocator model, plus directed scenario checks.
module tb_midi_voice_allocator;
  localparam int V = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_byte = '0;
  logic rx_valid = 1'b0;
  logic [3:0] channel = '0;
  logic [7*V-1:0] note_a, vel_a, note_b, vel_b;
  logic [V-1:0] gate_a, trig_a, gate_b, trig_b;
  logic ovf_a, ovf_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  midi_voice_allocator #(.VOICES(V), .OMNI(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .channel(channel),
    .voice_note(note_a), .voice_vel(vel_a), .voice_gate(gate_a), .voice_trig(trig_a),
    .overflow(ovf_a));

  midi_voice_allocator #(.VOICES(V), .OMNI(1)) dut_omni (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .channel(channel),
    .voice_note(note_b), .voice_vel(vel_b), .voice_gate(gate_b), .voice_trig(trig_b),
    .overflow(ovf_b));

  // reference model: index 0 = channel-filtered, 1 = omni
  int m_note[2][V], m_vel[2][V], m_gate[2][V], m_rank[2][V], m_trig[2][V];
  int m_ovf[2];
  int pend_kind[2], pend_note[2], pend_vel[2];  // 0 none, 1 on, 2 off, 3 all-off
  int p_st, p_status, p_d1;                     // 0 NOSTAT, 1 WAIT_D1, 2 WAIT_D2

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < V; i++) begin
        m_note[m][i] = 0; m_vel[m][i] = 0; m_gate[m][i] = 0; m_trig[m][i] = 0;
        m_rank[m][i] = i;
      end
      m_ovf[m] = 0; pend_kind[m] = 0; pend_note[m] = 0; pend_vel[m] = 0;
    end
    p_st = 0; p_status = 0; p_d1 = 0;
  endtask

  task automatic model_start(input int m, input int v, input int n, input int vl);
    int r;
    r = m_rank[m][v];
    for (int j = 0; j < V; j++) if (m_rank[m][j] < r) m_rank[m][j]++;
    m_rank[m][v] = 0;
    m_note[m][v] = n; m_vel[m][v] = vl; m_gate[m][v] = 1; m_trig[m][v] = 1;
  endtask

  task automatic model_apply(input int m);
    int v;
    for (int i = 0; i < V; i++) m_trig[m][i] = 0;
    m_ovf[m] = 0;
    v = -1;
    if (pend_kind[m] == 1) begin
      for (int i = V-1; i >= 0; i--) if (m_gate[m][i] == 1 && m_note[m][i] == pend_note[m]) v = i;
      if (v < 0) for (int i = V-1; i >= 0; i--) if (m_gate[m][i] == 0) v = i;
      if (v < 0) begin
        m_ovf[m] = 1;
`ifdef VOICE_STEAL_EN
        for (int i = 0; i < V; i++) if (m_rank[m][i] == V-1) v = i;
`endif
      end
      if (v >= 0) model_start(m, v, pend_note[m], pend_vel[m]);
    end else if (pend_kind[m] == 2) begin
      for (int i = 0; i < V; i++) if (m_gate[m][i] == 1 && m_note[m][i] == pend_note[m]) m_gate[m][i] = 0;
    end else if (pend_kind[m] == 3) begin
      for (int i = 0; i < V; i++) m_gate[m][i] = 0;
    end
    pend_kind[m] = 0;
  endtask

  task automatic model_parse(input bit v, input int b);
    int typ, k;
    if (!v) return;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin p_status = 0; p_st = 0; return; end
    if (b >= 'h80) begin p_status = b; p_st = 1; return; end
    typ = p_status / 16;
    if (p_st == 1) begin
      p_d1 = b;
      p_st = (typ == 'hC || typ == 'hD) ? 1 : 2;
    end else if (p_st == 2) begin
      p_st = 1;
      k = 0;
      if (typ == 9) k = (b != 0) ? 1 : 2;
      else if (typ == 8) k = 2;
      else if (typ == 'hB && p_d1 == 123) k = 3;
      for (int m = 0; m < 2; m++)
        if (m == 1 || (p_status % 16) == int'(channel)) begin
          pend_kind[m] = k; pend_note[m] = p_d1; pend_vel[m] = b;
        end
    end
  endtask

  task automatic check_all();
    logic [7*V-1:0] en, ev;
    logic [V-1:0] eg, et;
    string pfx;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < V; i++) begin
        en[7*i +: 7] = 7'(m_note[m][i]);
        ev[7*i +: 7] = 7'(m_vel[m][i]);
        eg[i] = m_gate[m][i][0];
        et[i] = m_trig[m][i][0];
      end
      pfx = (m == 0) ? "dut" : "omni";
      chk({pfx, ".note"}, 64'((m == 0) ? note_a : note_b), 64'(en));
      chk({pfx, ".vel"},  64'((m == 0) ? vel_a : vel_b),   64'(ev));
      chk({pfx, ".gate"}, 64'((m == 0) ? gate_a : gate_b), 64'(eg));
      chk({pfx, ".trig"}, 64'((m == 0) ? trig_a : trig_b), 64'(et));
      chk({pfx, ".ovf"},  64'((m == 0) ? ovf_a : ovf_b),   64'(m_ovf[m]));
    end
  endtask

  // called at a negedge; drives one cycle and checks after the next edge
  task automatic tick(input bit v, input logic [7:0] b);
    rx_valid = v; rx_byte = b;
    @(posedge clk);
    model_apply(0); model_apply(1);
    model_parse(v, int'(b));
    @(negedge clk);
    rx_valid = 1'b0;
    check_all();
  endtask

  task automatic send(input logic [7:0] b); tick(1'b1, b); endtask
  task automatic idle(); tick(1'b0, 8'h00); endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst.gate", 64'({gate_a, gate_b}), 64'd0);
    chk("rst.note", 64'({note_a, note_b}), 64'd0);
    chk("rst.vel",  64'({vel_a, vel_b}), 64'd0);
    chk("rst.trig_ovf", 64'({trig_a, trig_b, ovf_a, ovf_b}), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r, ch;
    logic [7:0] b;
    model_reset();
    @(negedge clk);
    do_reset();

    // note on / off
    channel = 4'd0;
    send(8'h90); send(8'h3C); send(8'h64); idle();
    chk("on.note0", 64'(note_a[6:0]), 64'd60);
    chk("on.vel0",  64'(vel_a[6:0]), 64'd100);
    chk("on.gate",  64'(gate_a), 64'b0001);
    chk("on.trig",  64'(trig_a), 64'b0001);
    idle();
    chk("on.trig_end", 64'(trig_a), 64'd0);
    send(8'h80); send(8'h3C); send(8'h00); idle();
    chk("off.gate", 64'(gate_a), 64'd0);
    chk("off.note_held", 64'(note_a[6:0]), 64'd60);

    // running status with interleaved real-time
    do_reset();
    send(8'h90); send(8'h3C); send(8'h40); send(8'h40); send(8'hF8); send(8'h50); idle();
    chk("rs.note0", 64'(note_a[6:0]), 64'd60);
    chk("rs.note1", 64'(note_a[13:7]), 64'd64);
    chk("rs.vel1",  64'(vel_a[13:7]), 64'd80);
    send(8'h3C); send(8'h00); idle();
    chk("rs.gate", 64'(gate_a), 64'b0010);

    // channel filter vs omni
    do_reset();
    channel = 4'd2;
    send(8'h91); send(8'h3C); send(8'h64); idle();
    chk("ch.wrong_gate", 64'(gate_a), 64'd0);
    chk("ch.omni_gate",  64'(gate_b), 64'b0001);
    send(8'h92); send(8'h3C); send(8'h64); idle();
    chk("ch.right_gate", 64'(gate_a), 64'b0001);
    chk("ch.omni_retrig", 64'(trig_b), 64'b0001);
    channel = 4'd0;

    // pool full
    do_reset();
    send(8'h90);
    send(8'h3C); send(8'h64); send(8'h3E); send(8'h64);
    send(8'h40); send(8'h64); send(8'h41); send(8'h64);
    send(8'h43); send(8'h64); idle();
    chk("full.ovf", 64'(ovf_a), 64'd1);
`ifdef VOICE_STEAL_EN
    chk("full.note0", 64'(note_a[6:0]), 64'd67);
    chk("full.trig",  64'(trig_a), 64'b0001);
`else
    chk("full.note0", 64'(note_a[6:0]), 64'd60);
    chk("full.trig",  64'(trig_a), 64'd0);
`endif
    chk("full.gate", 64'(gate_a), 64'b1111);
    idle();
    chk("full.ovf_end", 64'(ovf_a), 64'd0);

    // retrigger then all-off
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h64);
    send(8'h90); send(8'h3C); send(8'h20); idle();
    chk("rt.vel0", 64'(vel_a[6:0]), 64'd32);
    chk("rt.trig", 64'(trig_a), 64'b0001);
`ifdef VOICE_STEAL_EN
    // voice0 is newest, so the steal after filling lands on voice1
    send(8'h40); send(8'h64); send(8'h41); send(8'h64); send(8'h43); send(8'h64); idle();
    chk("rt.steal_note1", 64'(note_a[13:7]), 64'd67);
    chk("rt.steal_note0", 64'(note_a[6:0]), 64'd60);
`endif
    send(8'hB0); send(8'h7B); send(8'h00); idle();
    chk("alloff.gate", 64'(gate_a), 64'd0);

    // reset mid-message
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E);
    do_reset();
    send(8'h40); idle(); idle();
    chk("rstmid.gate", 64'(gate_a), 64'd0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 300 == 0) channel = 4'($urandom_range(0, 2));
      r = $urandom_range(0, 99);
      ch = $urandom_range(0, 2);
      if (r < 8)       b = 8'(8'h90 + ch);
      else if (r < 12) b = 8'(8'h80 + ch);
      else if (r < 14) b = 8'(8'hB0 + ch);
      else if (r < 15) b = 8'(8'hC0 + ch);
      else if (r < 16) b = 8'hF0;
      else if (r < 20) b = 8'(8'hF8 + $urandom_range(0, 7));
      else if (r < 22) b = 8'd123;
      else if (r < 30) b = 8'h00;
      else             b = 8'(8'h3C + $urandom_range(0, 7));
      tick(($urandom_range(0, 9) != 0), b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
